life_step_engine: RTL

Next-generation compute engine for the 4x16 Game of Life board. It sits on the selector port of the board memory (address, write data and write enable out; read data in) and is the only writer of that port. On a start pulse it reads all four rows, computes the next generation on a toroidal grid and writes the four new rows back, then pulses done. The VGA read port of the memory is untouched.

---
 rtl/life_step_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/life_step_engine.sv
// Next-generation engine for a toroidal Game of Life board held in a row-addressed memory.
// Reads all rows into a buffer, computes the next generation, then writes every row back in place.
module life_step_engine #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 16,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned GEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] array_selector,
  input  logic [COLS-1:0]   alive_out_selector,
  output logic [COLS-1:0]   alive_in_selector,
  output logic              write_enb,
  output logic              busy,
  output logic              done,
  output logic [GEN_W-1:0]  generation
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0]   row_q;
  logic [ROWS-1:0][COLS-1:0]   nxt_q;
  logic [ROWS-1:0][COLS-1:0]   nxt_c;
  logic [ADDR_W-1:0]           sel_q, sel_d;
  logic [COLS-1:0]             wdata_q, wdata_d;
  logic                        we_q, we_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [GEN_W-1:0]            gen_q, gen_d;
  logic                        capture;
  logic                        load_nxt;

  // Per-cell neighbour count with wrap-around on both axes.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int unsigned RU = (r + ROWS - 1) % ROWS;
    localparam int unsigned RD = (r + 1) % ROWS;
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int unsigned CL = (c + COLS - 1) % COLS;
      localparam int unsigned CR = (c + 1) % COLS;
      logic [3:0] n;
      assign n = 4'(row_q[RU][CL]) + 4'(row_q[RU][c]) + 4'(row_q[RU][CR])
               + 4'(row_q[r][CL])                     + 4'(row_q[r][CR])
               + 4'(row_q[RD][CL]) + 4'(row_q[RD][c]) + 4'(row_q[RD][CR]);
      assign nxt_c[r][c] = (n == 4'd3) | (row_q[r][c] & (n == 4'd2));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = '0;
    wdata_d  = '0;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    gen_d    = gen_q;
    capture  = 1'b0;
    load_nxt = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        capture = (cnt_q != '0);
        if (cnt_q == CNT_W'(ROWS)) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMPUTE: begin
        load_nxt = 1'b1;
        state_d  = S_WRITE;
        cnt_d    = '0;
      end
      S_WRITE: begin
        if (cnt_q == CNT_W'(ROWS - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave flops yet track the state.
    unique case (state_d)
      S_READ: begin
        busy_d = 1'b1;
        sel_d  = (cnt_d == CNT_W'(ROWS)) ? '0 : ADDR_W'(cnt_d);
      end
      S_COMPUTE: busy_d = 1'b1;
      S_WRITE: begin
        busy_d  = 1'b1;
        we_d    = 1'b1;
        sel_d   = ADDR_W'(cnt_d);
        wdata_d = (state_q == S_COMPUTE) ? nxt_c[0] : nxt_q[ADDR_W'(cnt_d)];
      end
      S_DONE: begin
        done_d = 1'b1;
        gen_d  = gen_q + GEN_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      nxt_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        row_q[ADDR_W'(cnt_q - CNT_W'(1))] <= alive_out_selector;
      end
      if (load_nxt) begin
        nxt_q <= nxt_c;
      end
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gen_q   <= gen_d;
    end
  end

  assign array_selector    = sel_q;
  assign alive_in_selector = wdata_q;
  assign write_enb         = we_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign generation        = gen_q;

endmodule
